// File: rtl/regrw_arbiter2.sv
// -----------------------------------------------------------------------------
// regrw_arbiter2
//
// Two-requester round-robin arbiter in front of a single 32-bit Avalon-MM
// register slave. One transaction is latched at a time, issued on the shared
// master port, held through slave waitrequest and the fixed read latency, and
// then completed to the granted requester with a single-cycle waitrequest drop.
//
// Parameters
//   AW            word address width on every port
//   READ_LATENCY  slave read latency in cycles after accept (0 = readdata is
//                 valid in the accept cycle)
//
// Ports
//   csi_MCLK_clk          clock, all logic on the rising edge
//   rsi_MRST_reset_n      asynchronous active-low reset
//   avs_m0_* / avs_m1_*   requester slave ports (address, writedata,
//                         byteenable, write, read in; readdata, waitrequest out)
//   avm_reg_*             master port to the shared register slave
//
// Every output is taken from a register or decoded from state plus latched
// transaction, so no requester input reaches an output combinationally.
// -----------------------------------------------------------------------------
module regrw_arbiter2 #(
    parameter int AW           = 4,
    parameter int READ_LATENCY = 0
) (
    input  logic          csi_MCLK_clk,
    input  logic          rsi_MRST_reset_n,

    input  logic [AW-1:0] avs_m0_address,
    input  logic [31:0]   avs_m0_writedata,
    input  logic [3:0]    avs_m0_byteenable,
    input  logic          avs_m0_write,
    input  logic          avs_m0_read,
    output logic [31:0]   avs_m0_readdata,
    output logic          avs_m0_waitrequest,

    input  logic [AW-1:0] avs_m1_address,
    input  logic [31:0]   avs_m1_writedata,
    input  logic [3:0]    avs_m1_byteenable,
    input  logic          avs_m1_write,
    input  logic          avs_m1_read,
    output logic [31:0]   avs_m1_readdata,
    output logic          avs_m1_waitrequest,

    output logic [AW-1:0] avm_reg_address,
    output logic [31:0]   avm_reg_writedata,
    output logic [3:0]    avm_reg_byteenable,
    output logic          avm_reg_write,
    output logic          avm_reg_read,
    input  logic [31:0]   avm_reg_readdata,
    input  logic          avm_reg_waitrequest
);

    // Latency counter is at least one bit wide even when it is never loaded.
    localparam int            CW       = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          ZERO_LAT = (READ_LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic            r_is_write;
    logic            r_grant;
    logic            r_last_grant;
    logic [31:0]     r_rdata;
    logic [CW-1:0]   r_cnt;

    logic            w_req0;
    logic            w_req1;
    logic            w_grant_sel;
    logic [AW-1:0]   w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic [3:0]      w_sel_be;
    logic            w_sel_is_write;

    logic            w_latch;
    logic            w_capture;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_done;

    assign w_req0 = avs_m0_read | avs_m0_write;
    assign w_req1 = avs_m1_read | avs_m1_write;

    // On a contest the port that did not win last time gets the slave; the
    // last-grant register resets to 1 so requester 0 wins the first contest.
    always_comb begin
        if (w_req0 & w_req1) begin
            w_grant_sel = ~r_last_grant;
        end else begin
            w_grant_sel = w_req1;
        end
    end

    // Write wins when a requester raises read and write together.
    always_comb begin
        if (w_grant_sel) begin
            w_sel_addr     = avs_m1_address;
            w_sel_wdata    = avs_m1_writedata;
            w_sel_be       = avs_m1_byteenable;
            w_sel_is_write = avs_m1_write;
        end else begin
            w_sel_addr     = avs_m0_address;
            w_sel_wdata    = avs_m0_writedata;
            w_sel_be       = avs_m0_byteenable;
            w_sel_is_write = avs_m0_write;
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_latch      = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!avm_reg_waitrequest) begin
                    if (r_is_write) begin
                        w_next_state = S_DONE;
                    end else if (ZERO_LAT) begin
                        w_capture    = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_cnt_load   = 1'b1;
                        w_next_state = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                // Counter holds READ_LATENCY on entry; data is due when it
                // reads 1, i.e. READ_LATENCY cycles after the accept cycle.
                if (r_cnt == CNT_ONE) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_is_write   <= 1'b0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rdata      <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_latch) begin
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_be       <= w_sel_be;
                r_is_write <= w_sel_is_write;
                r_grant    <= w_grant_sel;
            end
            if (w_capture) begin
                r_rdata <= avm_reg_readdata;
            end
            if (w_cnt_load) begin
                r_cnt <= CNT_LOAD;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Master port: latched fields drive the slave directly; strobes only
    // while issuing so they drop in RDWAIT and DONE.
    assign avm_reg_address    = r_addr;
    assign avm_reg_writedata  = r_wdata;
    assign avm_reg_byteenable = r_be;
    assign avm_reg_write      = (r_state == S_ISSUE) &  r_is_write;
    assign avm_reg_read       = (r_state == S_ISSUE) & ~r_is_write;

    // Requester ports: single-cycle release to the granted port only.
    assign avs_m0_waitrequest = ~((r_state == S_DONE) & ~r_grant);
    assign avs_m1_waitrequest = ~((r_state == S_DONE) &  r_grant);
    assign avs_m0_readdata    = r_rdata;
    assign avs_m1_readdata    = r_rdata;

endmodule

// File: tb/tb_regrw_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_regrw_arbiter2
//
// Two arbiter instances share one set of requester drivers: dut_a runs with
// READ_LATENCY = 0 against a zero-wait slave, dut_b with READ_LATENCY = 2
// against a slave returning data two cycles after accept. 'sel' picks which
// instance's outputs are being observed. Directed vectors, hand-written
// corner sequences and a randomized run against a transaction-timeline model.
// -----------------------------------------------------------------------------
module tb_regrw_arbiter2;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic slv_wait;

    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wd, m1_wd;
    logic [3:0]    m0_be, m1_be;
    logic          m0_write, m0_read, m1_write, m1_read;

    logic [31:0]   a_m0_rd, a_m1_rd, b_m0_rd, b_m1_rd;
    logic          a_m0_wait, a_m1_wait, b_m0_wait, b_m1_wait;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_wd, b_wd, a_rdata, b_rdata;
    logic [3:0]    a_be, b_be;
    logic          a_wr, a_rd, b_wr, b_rd;

    logic [31:0] mem_a [16] = '{default: 32'h0};
    logic [31:0] mem_b [16] = '{default: 32'h0};
    logic [31:0] b_d1, b_d2;
    logic        b_v1 = 1'b0;
    logic        b_v2 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regrw_arbiter2 #(.AW(AW), .READ_LATENCY(0)) dut_a (
        .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
        .avs_m0_address(m0_addr), .avs_m0_writedata(m0_wd), .avs_m0_byteenable(m0_be),
        .avs_m0_write(m0_write), .avs_m0_read(m0_read),
        .avs_m0_readdata(a_m0_rd), .avs_m0_waitrequest(a_m0_wait),
        .avs_m1_address(m1_addr), .avs_m1_writedata(m1_wd), .avs_m1_byteenable(m1_be),
        .avs_m1_write(m1_write), .avs_m1_read(m1_read),
        .avs_m1_readdata(a_m1_rd), .avs_m1_waitrequest(a_m1_wait),
        .avm_reg_address(a_addr), .avm_reg_writedata(a_wd), .avm_reg_byteenable(a_be),
        .avm_reg_write(a_wr), .avm_reg_read(a_rd),
        .avm_reg_readdata(a_rdata), .avm_reg_waitrequest(slv_wait)
    );

    regrw_arbiter2 #(.AW(AW), .READ_LATENCY(2)) dut_b (
        .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rst_n),
        .avs_m0_address(m0_addr), .avs_m0_writedata(m0_wd), .avs_m0_byteenable(m0_be),
        .avs_m0_write(m0_write), .avs_m0_read(m0_read),
        .avs_m0_readdata(b_m0_rd), .avs_m0_waitrequest(b_m0_wait),
        .avs_m1_address(m1_addr), .avs_m1_writedata(m1_wd), .avs_m1_byteenable(m1_be),
        .avs_m1_write(m1_write), .avs_m1_read(m1_read),
        .avs_m1_readdata(b_m1_rd), .avs_m1_waitrequest(b_m1_wait),
        .avm_reg_address(b_addr), .avm_reg_writedata(b_wd), .avm_reg_byteenable(b_be),
        .avm_reg_write(b_wr), .avm_reg_read(b_rd),
        .avm_reg_readdata(b_rdata), .avm_reg_waitrequest(slv_wait)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Register slaves: zero-wait combinational readdata for dut_a, two-cycle
    // read latency for dut_b; garbage whenever data is not due.
    assign a_rdata = (a_rd && !slv_wait) ? mem_a[a_addr] : 32'hBAD0_BAD0;
    assign b_rdata = b_v2 ? b_d2 : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (a_wr && !slv_wait) mem_a[a_addr] <= merge(mem_a[a_addr], a_wd, a_be);
        if (b_wr && !slv_wait) mem_b[b_addr] <= merge(mem_b[b_addr], b_wd, b_be);
        b_v1 <= b_rd && !slv_wait;
        b_d1 <= mem_b[b_addr];
        b_v2 <= b_v1;
        b_d2 <= b_d1;
    end

    // Observed instance
    logic          m0_wait, m1_wait, avm_wr, avm_rd;
    logic [31:0]   m0_rd, m1_rd, avm_wd;
    logic [AW-1:0] avm_addr;
    logic [3:0]    avm_be;
    assign m0_wait  = sel ? b_m0_wait : a_m0_wait;
    assign m1_wait  = sel ? b_m1_wait : a_m1_wait;
    assign m0_rd    = sel ? b_m0_rd   : a_m0_rd;
    assign m1_rd    = sel ? b_m1_rd   : a_m1_rd;
    assign avm_wr   = sel ? b_wr      : a_wr;
    assign avm_rd   = sel ? b_rd      : a_rd;
    assign avm_addr = sel ? b_addr    : a_addr;
    assign avm_wd   = sel ? b_wd      : a_wd;
    assign avm_be   = sel ? b_be      : a_be;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic wr, input logic rd, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            m0_write = wr; m0_read = rd; m0_addr = a; m0_wd = d; m0_be = be;
        end else begin
            m1_write = wr; m1_read = rd; m1_addr = a; m1_wd = d; m1_be = be;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        slv_wait = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // m0 write and m1 read both pending at cycle 0: m0 must finish at d0,
    // m1 (read of a1) at d1 with readdata rd1.
    task automatic run_pair(input string nm, input int d0, input int d1,
                            input logic [3:0] a1, input logic [31:0] rd1);
        for (int k = 0; k <= d1; k++) begin
            #1;
            chk1($sformatf("%s_m0_wait_c%0d", nm, k), m0_wait, k != d0);
            chk1($sformatf("%s_m1_wait_c%0d", nm, k), m1_wait, k != d1);
            if (k == d1 - 1) begin
                chk1({nm, "_m1_strobe"}, avm_rd, 1'b1);
                chk32({nm, "_m1_addr"}, 32'(avm_addr), 32'(a1));
            end
            if (k == d1) chk32({nm, "_m1_rdata"}, m1_rd, rd1);
            tick();
            if (k == d0) drive(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        end
        drive(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    endtask

    // Randomized traffic on the selected instance. The model works on a
    // transaction timeline: when the fabric is free, the first cycle with any
    // request decides the grant; the strobe is due from the next cycle until
    // the slave accepts; completion is one cycle after accept plus the read
    // latency; the reference memory follows completed writes.
    task automatic run_random(input logic s, input int ncyc);
        int          lat, n, g, arb_c, acc_c, done_c, dp;
        logic        busy, ml, exp_str;
        logic [31:0] refm [16];
        logic        req [2];
        logic        twr [2];
        logic [3:0]  ta  [2];
        logic [31:0] td  [2];
        logic [3:0]  tbe [2];
        logic        dprev [2];
        logic        gw;
        logic [3:0]  ga, gbe;
        logic [31:0] gd;
        do_reset();
        sel = s;
        lat = s ? 2 : 0;
        for (int i = 0; i < 16; i++) refm[i] = s ? mem_b[i] : mem_a[i];
        busy = 1'b0; ml = 1'b1; g = 0; arb_c = 0; acc_c = -1; done_c = -1;
        gw = 1'b0; ga = '0; gbe = '0; gd = '0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; dprev[p] = 1'b0; twr[p] = 1'b0;
            ta[p] = '0; td[p] = '0; tbe[p] = '0;
        end
        n = 0;
        while (n < ncyc || busy || req[0] || req[1]) begin
            if (n > ncyc + 60) begin
                n_chk++; n_fail++;
                $display("FAIL rand%0d_drain: got pending after %0d cycles, want idle", s, n);
                break;
            end
            for (int p = 0; p < 2; p++) begin
                if (req[p] && dprev[p]) begin
                    req[p] = 1'b0;
                    drive(p, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
                end
                if (!req[p] && n < ncyc && $urandom_range(0, 2) != 0) begin
                    req[p] = 1'b1;
                    twr[p] = 1'($urandom_range(0, 1));
                    ta[p]  = 4'($urandom_range(0, 15));
                    td[p]  = $urandom;
                    tbe[p] = 4'($urandom_range(0, 15));
                    drive(p, twr[p], !twr[p] || ($urandom_range(0, 3) == 0), ta[p], td[p], tbe[p]);
                end
            end
            slv_wait = ($urandom_range(0, 3) == 0);
            #1;
            if (!busy && (req[0] || req[1])) begin
                g = (req[0] && req[1]) ? (ml ? 0 : 1) : (req[1] ? 1 : 0);
                busy = 1'b1; arb_c = n; acc_c = -1; done_c = -1;
                gw = twr[g]; ga = ta[g]; gd = td[g]; gbe = tbe[g];
            end
            exp_str = busy && (n > arb_c) && (acc_c < 0);
            chk1($sformatf("rand%0d_wr_c%0d", s, n), avm_wr, exp_str && gw);
            chk1($sformatf("rand%0d_rd_c%0d", s, n), avm_rd, exp_str && !gw);
            if (exp_str) begin
                chk32($sformatf("rand%0d_addr_c%0d", s, n), 32'(avm_addr), 32'(ga));
                chk32($sformatf("rand%0d_be_c%0d", s, n), 32'(avm_be), 32'(gbe));
                if (gw) chk32($sformatf("rand%0d_wd_c%0d", s, n), avm_wd, gd);
                if (!slv_wait) begin
                    acc_c  = n;
                    done_c = n + 1 + (gw ? 0 : lat);
                end
            end
            dp = (busy && acc_c >= 0 && n == done_c) ? g : -1;
            chk1($sformatf("rand%0d_m0_wait_c%0d", s, n), m0_wait, dp != 0);
            chk1($sformatf("rand%0d_m1_wait_c%0d", s, n), m1_wait, dp != 1);
            if (dp >= 0) begin
                if (gw) refm[ga] = merge(refm[ga], gd, gbe);
                else chk32($sformatf("rand%0d_rdata_c%0d", s, n), (g == 0) ? m0_rd : m1_rd, refm[ga]);
                ml = (g == 1);
                busy = 1'b0;
            end
            dprev[0] = !m0_wait;
            dprev[1] = !m1_wait;
            tick();
            n++;
        end
        drive(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        slv_wait = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        int          port;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          stall;
        int          done_cyc;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 11;

    initial begin
        vec_t tbl [NV];
        int   got, cnt, own;
        logic exp_str;

        tbl[0]  = '{1'b0, 0, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF, 0, 2, 32'h0};
        tbl[1]  = '{1'b0, 1, 1'b0, 4'd2, 32'h0,        4'hF, 0, 2, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 0, 1'b1, 4'd2, 32'hAAAA5555, 4'h3, 3, 5, 32'h0};
        tbl[3]  = '{1'b0, 1, 1'b0, 4'd2, 32'h0,        4'hF, 1, 3, 32'hDEAD5555};
        tbl[4]  = '{1'b1, 1, 1'b1, 4'd5, 32'hCAFEF00D, 4'hF, 0, 2, 32'h0};
        tbl[5]  = '{1'b1, 1, 1'b0, 4'd5, 32'h0,        4'hF, 0, 4, 32'hCAFEF00D};
        tbl[6]  = '{1'b1, 0, 1'b0, 4'd5, 32'h0,        4'hF, 2, 6, 32'hCAFEF00D};
        tbl[7]  = '{1'b0, 0, 1'b1, 4'd7, 32'h12345678, 4'hC, 0, 2, 32'h0};
        tbl[8]  = '{1'b0, 0, 1'b0, 4'd7, 32'h0,        4'hF, 0, 2, 32'h12340000};
        tbl[9]  = '{1'b1, 0, 1'b1, 4'd0, 32'hFFFFFF5A, 4'h1, 0, 2, 32'h0};
        tbl[10] = '{1'b1, 1, 1'b0, 4'd0, 32'h0,        4'hF, 1, 5, 32'h0000005A};

        // Reset values on both instances
        sel = 1'b0;
        rst_n = 1'b0;
        slv_wait = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk1($sformatf("rst%0d_wr", s), avm_wr, 1'b0);
            chk1($sformatf("rst%0d_rd", s), avm_rd, 1'b0);
            chk32($sformatf("rst%0d_addr", s), 32'(avm_addr), 32'h0);
            chk32($sformatf("rst%0d_wd", s), avm_wd, 32'h0);
            chk32($sformatf("rst%0d_be", s), 32'(avm_be), 32'h0);
            chk1($sformatf("rst%0d_m0_wait", s), m0_wait, 1'b1);
            chk1($sformatf("rst%0d_m1_wait", s), m1_wait, 1'b1);
            chk32($sformatf("rst%0d_m0_rd", s), m0_rd, 32'h0);
            chk32($sformatf("rst%0d_m1_rd", s), m1_rd, 32'h0);
        end
        sel = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Directed single transactions, cycle 0 = request presented in IDLE
        for (int i = 0; i < NV; i++) begin
            sel = tbl[i].sel;
            own = tbl[i].port;
            drive(own, tbl[i].wr, !tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
            for (int k = 0; k <= tbl[i].done_cyc; k++) begin
                slv_wait = (k >= 1 && k <= tbl[i].stall);
                #1;
                exp_str = (k >= 1 && k <= 1 + tbl[i].stall);
                chk1($sformatf("vec%0d_wr_c%0d", i, k), avm_wr, exp_str && tbl[i].wr);
                chk1($sformatf("vec%0d_rd_c%0d", i, k), avm_rd, exp_str && !tbl[i].wr);
                if (exp_str) begin
                    chk32($sformatf("vec%0d_addr_c%0d", i, k), 32'(avm_addr), 32'(tbl[i].addr));
                    chk32($sformatf("vec%0d_be_c%0d", i, k), 32'(avm_be), 32'(tbl[i].be));
                    if (tbl[i].wr) chk32($sformatf("vec%0d_wd_c%0d", i, k), avm_wd, tbl[i].wd);
                end
                chk1($sformatf("vec%0d_own_wait_c%0d", i, k), (own == 0) ? m0_wait : m1_wait,
                     k != tbl[i].done_cyc);
                chk1($sformatf("vec%0d_other_wait_c%0d", i, k), (own == 0) ? m1_wait : m0_wait, 1'b1);
                if (k == tbl[i].done_cyc && !tbl[i].wr)
                    chk32($sformatf("vec%0d_rdata", i), (own == 0) ? m0_rd : m1_rd, tbl[i].rd);
                tick();
            end
            drive(own, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
            slv_wait = 1'b0;
            for (int k = 0; k < 4; k++) tick();
        end

        // Simultaneous m0 write / m1 read after reset: m0 first, m1 sees the new data
        sel = 1'b0;
        do_reset();
        drive(0, 1'b1, 1'b0, 4'd2, 32'h12345678, 4'hF);
        drive(1, 1'b0, 1'b1, 4'd2, 32'h0, 4'hF);
        run_pair("contest", 2, 5, 4'd2, 32'h12345678);
        tick();

        // Both requesting continuously: grants alternate 0,1,0,1,...
        do_reset();
        drive(0, 1'b1, 1'b0, 4'd9, 32'h00000011, 4'hF);
        drive(1, 1'b0, 1'b1, 4'd9, 32'h0, 4'hF);
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 8; k++) begin
            #1;
            got = -1;
            if (!m0_wait && !m1_wait) begin
                n_chk++; n_fail++;
                $display("FAIL alt_both_low: got both waitrequests low at cycle %0d, want one", k);
            end else if (!m0_wait) got = 0;
            else if (!m1_wait) got = 1;
            if (got >= 0) begin
                chk32($sformatf("alt_grant%0d", cnt), 32'(got), 32'(cnt % 2));
                if (got == 1) chk32($sformatf("alt_rdata%0d", cnt), m1_rd, 32'h00000011);
                cnt++;
            end
            tick();
        end
        chk32("alt_count", 32'(cnt), 32'd8);
        drive(0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);

        // Reset asserted while a read is being issued, then re-arbitration
        do_reset();
        drive(1, 1'b0, 1'b1, 4'd2, 32'h0, 4'hF);
        slv_wait = 1'b1;
        tick();
        #1;
        chk1("rstmid_pre_strobe", avm_rd, 1'b1);
        drive(0, 1'b1, 1'b0, 4'd3, 32'h0BADF00D, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rstmid_wr", avm_wr, 1'b0);
        chk1("rstmid_rd", avm_rd, 1'b0);
        chk1("rstmid_m0_wait", m0_wait, 1'b1);
        chk1("rstmid_m1_wait", m1_wait, 1'b1);
        chk32("rstmid_m1_rd", m1_rd, 32'h0);
        tick();
        rst_n = 1'b1;
        slv_wait = 1'b0;
        run_pair("rstrel", 2, 5, 4'd2, 32'h12345678);
        tick();

        // Randomized traffic on both latency variants
        run_random(1'b0, 300);
        run_random(1'b1, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test by %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regrw_arbiter2.md
# regrw_arbiter2

Two-port round-robin arbiter sharing one 32-bit Avalon-MM register slave between two Avalon-MM masters (e.g. MCU bridge and an on-chip sequencer). Each master sees a normal slave port with waitrequest; the block latches one transaction at a time, issues it on its single master port, waits out slave waitrequest and fixed read latency, then completes it to the granted requester. Sits in the Qsys fabric between the requesters and a byte-enabled register slave with zero-wait, combinational readdata.

## Interface
- AW, 4, address width (word addresses) on all ports
- READ_LATENCY, 0, slave read latency in cycles after read accept (0 = readdata valid in the accept cycle)
- csi_MCLK_clk  in  1  single clock, all logic on rising edge
- rsi_MRST_reset_n  in  1  asynchronous, active-low reset
- avs_m0_address / avs_m1_address  in  AW  requester word address
- avs_m0_writedata / avs_m1_writedata  in  32  write data
- avs_m0_byteenable / avs_m1_byteenable  in  4  byte lanes
- avs_m0_write / avs_m1_write  in  1  write request
- avs_m0_read / avs_m1_read  in  1  read request
- avs_m0_readdata / avs_m1_readdata  out  32  read data, valid when own waitrequest low after a read
- avs_m0_waitrequest / avs_m1_waitrequest  out  1  stall; low exactly one cycle at completion
- avm_reg_address  out  AW  to shared slave
- avm_reg_writedata  out  32
- avm_reg_byteenable  out  4
- avm_reg_write  out  1
- avm_reg_read  out  1
- avm_reg_readdata  in  32
- avm_reg_waitrequest  in  1

## Operation
- States: IDLE, ISSUE, RDWAIT, DONE. Reset state IDLE.
- IDLE: request_i = avs_mi_read | avs_mi_write. None -> stay. One -> grant it. Both -> grant the port not granted last (last_grant reset = 1, so m0 wins first contest). Latch address, writedata, byteenable, is_write (write has priority if both read and write high; read ignored) and grant. -> ISSUE.
- ISSUE: avm_reg_* driven from latch; avm_reg_write = is_write, avm_reg_read = ~is_write. Hold stable while avm_reg_waitrequest = 1. On accept (waitrequest 0): write -> DONE; read with READ_LATENCY = 0 -> capture avm_reg_readdata, DONE; read with READ_LATENCY > 0 -> load counter = READ_LATENCY, RDWAIT.
- RDWAIT: avm_reg_read/write low; decrement each cycle; capture avm_reg_readdata and -> DONE in the cycle the counter reaches 1 on entry (i.e. READ_LATENCY cycles after accept).
- DONE: avs_m{grant}_waitrequest = 0 for this one cycle; last_grant <= grant; -> IDLE.
- Readdata: one 32-bit capture register fanned to both avs_mi_readdata; holds value until next read capture. Reset 0.
- Counter width: ceil(log2(READ_LATENCY+1)), minimum 1.
- Requester dropping request mid-transaction (protocol violation): latched transaction still completes on slave; DONE pulse still issued.

## Timing
- Reset values: avm_reg_read/write 0, avm_reg_address/writedata/byteenable 0, both avs waitrequest 1, both readdata 0, last_grant 1, state IDLE.
- All outputs registered or decoded from state/latch only; no combinational path from avs_* inputs to any output.
- Request seen in IDLE at cycle 0 -> avm strobe cycle 1 -> DONE cycle 2 (+ slave stall cycles, + READ_LATENCY for reads). Minimum 3 cycles per transaction.
- Non-granted requester waitrequest stays 1 throughout; served next IDLE cycle after DONE.
- Reset asserted mid-transaction: immediate return to reset values; in-flight transaction abandoned (slave may or may not have accepted it); after release, pending requests re-arbitrated with m0 priority.

## Test plan
- m0 write addr 2, data 0xDEADBEEF, be 0xF, slave no-wait -> avm_reg_write high cycle 1 only with those values; avs_m0_waitrequest low in cycle 2 only; avs_m1_waitrequest constant 1.
- After reset m0 write 0x12345678 and m1 read addr 2 in same cycle -> m0 completes first; m1 read issued next, avs_m1_readdata = 0x12345678 when its waitrequest drops.
- m0 write be 0x3, data 0xAAAA5555, avm_reg_waitrequest held 3 cycles -> avm signals stable 4 cycles, DONE cycle after accept, slave low half updated only.
- READ_LATENCY = 2, m1 read, slave returns 0xCAFEF00D 2 cycles after accept -> avs_m1_readdata = 0xCAFEF00D with waitrequest low exactly at cycle accept+3.
- Both masters requesting continuously for 8 transactions -> grants alternate 0,1,0,1,...; no port starved.
- Reset asserted during ISSUE -> avm_reg_read/write 0 and both waitrequests 1 immediately; after release pending m1 and m0 requests -> m0 served first.
